// File: rtl/cache_arbiter.sv
// Two-requester (I-cache / D-cache) arbiter in front of one physical-memory port.
// Round-robin on simultaneous requests; one transfer at a time, IDLE -> XFER -> RESP.
module cache_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t            state, next_state;
  logic              last_grant;   // 0 = I-cache, 1 = D-cache
  logic              grant_d;
  logic              is_write;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] line_buf;
  logic              i_req, d_req, grant, pick_d;

  assign i_req = i_read;
  assign d_req = d_read | d_write;
  assign grant = (state == IDLE) && (i_req || d_req);

  always_comb begin
    pick_d = d_req;
    if (i_req && d_req) pick_d = ~last_grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant) next_state = XFER;
      XFER:    if (pmem_resp) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    case (state)
      XFER: begin
        pmem_read  = ~is_write;
        pmem_write = is_write;
      end
      RESP: begin
        i_resp = ~grant_d;
        d_resp = grant_d;
      end
      default: ;
    endcase
  end

  // Request is captured at grant so requesters may change their inputs mid-transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b0;
      grant_d    <= 1'b0;
      is_write   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      line_buf   <= '0;
    end else begin
      if (grant) begin
        last_grant <= pick_d;
        grant_d    <= pick_d;
        is_write   <= pick_d & d_write;
        addr_q     <= pick_d ? d_addr : i_addr;
        wdata_q    <= pick_d ? d_wdata : '0;
      end
      if (state == XFER && pmem_resp && !is_write) line_buf <= pmem_rdata;
    end
  end

  assign pmem_addr  = addr_q;
  assign pmem_wdata = wdata_q;
  assign i_rdata    = line_buf;
  assign d_rdata    = line_buf;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios plus randomized transactions
// predicted by a transaction-level round-robin model.
module tb_cache_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk, rst_n;
  logic              i_read, d_read, d_write;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [LINE_W-1:0] i_rdata, d_rdata, d_wdata;
  logic              i_resp, d_resp;
  logic              pmem_read, pmem_write, pmem_resp, busy;
  logic [ADDR_W-1:0] pmem_addr;
  logic [LINE_W-1:0] pmem_wdata, pmem_rdata;

  int checks = 0;
  int failures = 0;

  // Model state: who was served last (0 = I, 1 = D) and the last line read back.
  logic              m_last;
  logic [LINE_W-1:0] m_buf;

  cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] r;
    for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic pick(input logic ir, input logic dr);
    if (ir && dr) return !m_last;
    return dr;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rd"}, pmem_read, 0);
    chk({tag, "_wr"}, pmem_write, 0);
    chk({tag, "_iresp"}, i_resp, 0);
    chk({tag, "_dresp"}, d_resp, 0);
  endtask

  // Entered at a falling edge in IDLE with requests already driven.
  // mode 0: drop requests in the resp cycle; 1: keep them; 2: drop right after grant.
  task automatic serve(input logic who, input logic wr, input logic [ADDR_W-1:0] addr,
                       input logic [LINE_W-1:0] wdata, input int lat,
                       input logic [LINE_W-1:0] rdata, input int mode);
    @(negedge clk);
    for (int k = 0; k < lat; k++) begin
      chk("xfer_busy", busy, 1);
      chk("xfer_read", pmem_read, !wr);
      chk("xfer_write", pmem_write, wr);
      chk("xfer_addr", pmem_addr, addr);
      if (wr) chk("xfer_wdata", pmem_wdata, wdata);
      chk("xfer_resps", {i_resp, d_resp}, 0);
      if (k == 0 && mode != 1) begin
        d_wdata = rand_line();
        d_addr  = $urandom;
        i_addr  = $urandom;
        if (mode == 2) begin i_read = 0; d_read = 0; d_write = 0; end
      end
      if (k == lat - 1) begin
        pmem_resp  = 1'b1;
        pmem_rdata = rdata;
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    pmem_resp  = 1'b0;
    pmem_rdata = rand_line();
    if (!wr) m_buf = rdata;
    m_last = who;
    chk("resp_i", i_resp, !who);
    chk("resp_d", d_resp, who);
    chk("resp_irdata", i_rdata, m_buf);
    chk("resp_drdata", d_rdata, m_buf);
    chk("resp_busy", busy, 1);
    chk("resp_strobes", {pmem_read, pmem_write}, 0);
    if (mode == 0) begin i_read = 0; d_read = 0; d_write = 0; end
    @(negedge clk);
    chk_quiet("idle");
  endtask

  initial begin
    logic ir, dr, dw, who, wr;
    logic [ADDR_W-1:0] a;
    rst_n = 0; i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; pmem_rdata = '0;
    m_last = 1'b0; m_buf = '0;
    #2;
    chk_quiet("reset");
    chk("reset_addr", pmem_addr, 0);
    chk("reset_wdata", pmem_wdata, 0);
    chk("reset_rdata", i_rdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    // Both requesting after reset: D, then I, then D.
    i_read = 1; i_addr = 32'h100; d_read = 1; d_addr = 32'h200;
    serve(1, 0, 32'h200, '0, 2, rand_line(), 1);
    serve(0, 0, 32'h100, '0, 1, rand_line(), 1);
    serve(1, 0, 32'h200, '0, 3, rand_line(), 0);

    // Plain I fill with a three-cycle memory.
    i_read = 1; i_addr = 32'h0000_1000;
    serve(0, 0, 32'h1000, '0, 3, {32{8'hAA}}, 0);

    // D writeback; data scrambled mid-transfer must not leak through.
    d_write = 1; d_addr = 32'h80; d_wdata = {32{8'h55}};
    serve(1, 1, 32'h80, {32{8'h55}}, 2, rand_line(), 0);

    // Read and write together is a write.
    d_read = 1; d_write = 1; d_addr = 32'h40; d_wdata = rand_line();
    serve(1, 1, 32'h40, d_wdata, 2, rand_line(), 0);

    // Requester drops right after grant.
    i_read = 1; i_addr = 32'h2000;
    serve(0, 0, 32'h2000, '0, 4, rand_line(), 2);

    // Reset in the middle of a transfer, then a stray memory response.
    i_read = 1; i_addr = 32'h3000;
    @(negedge clk);
    chk("rstx_read", pmem_read, 1);
    #2 rst_n = 0;
    #1;
    chk("rstx_read0", pmem_read, 0);
    chk("rstx_busy0", busy, 0);
    chk("rstx_addr0", pmem_addr, 0);
    chk("rstx_buf0", i_rdata, 0);
    i_read = 0; m_last = 1'b0; m_buf = '0;
    @(negedge clk);
    chk_quiet("rst_hold");
    rst_n = 1; pmem_resp = 1;
    @(negedge clk);
    chk_quiet("stray1");
    pmem_resp = 0;
    @(negedge clk);
    chk_quiet("stray2");

    // Randomized traffic against the model.
    for (int n = 0; n < 30; n++) begin
      ir = 1'($urandom); dr = 1'($urandom); dw = 1'($urandom);
      if (!ir && !dr && !dw) ir = 1;
      i_read = ir; d_read = dr; d_write = dw;
      i_addr = $urandom; d_addr = $urandom; d_wdata = rand_line();
      who = pick(ir, dr | dw);
      wr  = who & dw;
      a   = who ? d_addr : i_addr;
      serve(who, wr, a, d_wdata, $urandom_range(1, 4), rand_line(), ($urandom % 2) ? 0 : 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
